// File: rtl/irq_coalescer_pkg.sv
// Shared definitions for the interrupt coalescer: channel state encoding and
// the fixed pulse-shaping lengths seen by the downstream MSI arbiter.
// Latency: n/a (package). Backpressure: n/a.
package irq_coalescer_pkg;

  // Per-channel FSM encoding.
  typedef enum logic [1:0] {
    Idle_St    = 2'd0,
    Collect_St = 2'd1,
    Fire_St    = 2'd2,
    Gap_St     = 2'd3
  } chan_state_e;

  // Output pulse high time and mandatory low time afterwards, in clock cycles.
  localparam int FirePulse_Con = 2;
  localparam int GapLen_Con    = 2;

  // Upper bound on the number of interrupt sources.
  localparam int MaxSources_Con = 32;

  // Width of the phase counter that times Fire_St and Gap_St; must hold
  // max(FirePulse_Con, GapLen_Con) - 1.
  localparam int PhaseWidth_Con = 2;

endpackage

// File: rtl/irq_coalescer_chan.sv
// One coalescing channel: counts event pulses, fires a shaped interrupt when
// the batch threshold is met or the holdoff timer runs out.
// Latency: event -> irq 1 cycle when threshold is 1. Backpressure: none; events
// arriving while firing or in the gap are counted into the next batch.
// Ports: clk/rst_n (async active-low), enable, event_pulse, threshold (already
// mapped to >= 1), holdoff, ovf_clr -> irq (registered), overflow (sticky), pending.
module irq_coalescer_chan
  import irq_coalescer_pkg::*;
#(
  parameter int CountWidth_Gen = 8,
  parameter int TimerWidth_Gen = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      event_pulse,
  input  logic [CountWidth_Gen-1:0] threshold,
  input  logic [TimerWidth_Gen-1:0] holdoff,
  input  logic                      ovf_clr,
  output logic                      irq,
  output logic                      overflow,
  output logic                      pending
);

  localparam int CW = CountWidth_Gen;
  localparam int TW = TimerWidth_Gen;
  localparam logic [PhaseWidth_Con-1:0] FireLast = PhaseWidth_Con'(FirePulse_Con - 1);
  localparam logic [PhaseWidth_Con-1:0] GapLast  = PhaseWidth_Con'(GapLen_Con - 1);

  chan_state_e               state_q, state_d;
  logic [CW-1:0]             count_q, count_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic [PhaseWidth_Con-1:0] phase_q, phase_d;
  logic                      irq_q, irq_d;
  logic                      ovf_q, ovf_d;

  logic          cnt_max;
  logic [CW-1:0] count_ev;
  logic          ovf_set;
  logic          timer_expire;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    timer_d      = timer_q;
    phase_d      = phase_q;
    cnt_max      = (count_q == '1);
    // Count including this cycle's event, saturating at all-ones.
    count_ev     = (event_pulse && !cnt_max) ? count_q + CW'(1) : count_q;
    ovf_set      = enable && event_pulse && cnt_max;
    // A loaded timer of 1 reaches zero at this edge; a timer loaded with 0
    // never passes through 1, so a zero holdoff never forces a fire.
    timer_expire = (timer_q == TW'(1));

    unique case (state_q)
      Idle_St: begin
        if (event_pulse) begin
          timer_d = holdoff;
          phase_d = '0;
          if (CW'(1) >= threshold) begin
            state_d = Fire_St;
            count_d = '0;
          end else begin
            state_d = Collect_St;
            count_d = CW'(1);
          end
        end
      end
      Collect_St: begin
        count_d = count_ev;
        if (timer_q != '0) timer_d = timer_q - TW'(1);
        // Both fire causes collapse into one transition, hence one pulse.
        if ((count_ev >= threshold) || timer_expire) begin
          state_d = Fire_St;
          count_d = '0;
          timer_d = '0;
          phase_d = '0;
        end
      end
      Fire_St: begin
        count_d = count_ev;
        if (phase_q == FireLast) begin
          state_d = Gap_St;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PhaseWidth_Con'(1);
        end
      end
      Gap_St: begin
        count_d = count_ev;
        if (phase_q == GapLast) begin
          phase_d = '0;
          if (count_ev != '0) begin
            state_d = Collect_St;
            timer_d = holdoff;
          end else begin
            state_d = Idle_St;
          end
        end else begin
          phase_d = phase_q + PhaseWidth_Con'(1);
        end
      end
      default: state_d = Idle_St;
    endcase

    // Disabling flushes the channel; the sticky overflow flag is kept.
    if (!enable) begin
      state_d = Idle_St;
      count_d = '0;
      timer_d = '0;
      phase_d = '0;
    end

    irq_d = (state_d == Fire_St);
    // A new overflow in the same cycle as a clear must stay visible.
    ovf_d = ovf_set | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= Idle_St;
      count_q <= '0;
      timer_q <= '0;
      phase_q <= '0;
      irq_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      timer_q <= timer_d;
      phase_q <= phase_d;
      irq_q   <= irq_d;
      ovf_q   <= ovf_d;
    end
  end

  assign irq      = irq_q;
  assign overflow = ovf_q;
  assign pending  = (state_q != Idle_St);

endmodule

// File: rtl/irq_coalescer.sv
// Per-source interrupt moderation in front of the MSI arbiter: batches event
// pulses and emits one clean, gap-separated interrupt pulse per batch.
// Latency: 1 cycle from event to IrqOut at threshold 1. Backpressure: none.
// Ports: SysClk_ClkIn, SysRstN_RstIn (async active-low), Enable_EnIn,
// Event_DatIn[N], Threshold_DatIn[CW], Holdoff_DatIn[TW], OverflowClr_DatIn[N]
// -> IrqOut_DatOut[N], Overflow_DatOut[N], Pending_DatOut[N].
module irq_coalescer
  import irq_coalescer_pkg::*;
#(
  parameter int NumberOfInterrupts_Gen = 5,
  parameter int CountWidth_Gen         = 8,
  parameter int TimerWidth_Gen         = 16
) (
  input  logic                              SysClk_ClkIn,
  input  logic                              SysRstN_RstIn,
  input  logic                              Enable_EnIn,
  input  logic [NumberOfInterrupts_Gen-1:0] Event_DatIn,
  input  logic [CountWidth_Gen-1:0]         Threshold_DatIn,
  input  logic [TimerWidth_Gen-1:0]         Holdoff_DatIn,
  input  logic [NumberOfInterrupts_Gen-1:0] OverflowClr_DatIn,
  output logic [NumberOfInterrupts_Gen-1:0] IrqOut_DatOut,
  output logic [NumberOfInterrupts_Gen-1:0] Overflow_DatOut,
  output logic [NumberOfInterrupts_Gen-1:0] Pending_DatOut
);

  // A zero threshold would mean "fire on nothing"; treat it as one event.
  logic [CountWidth_Gen-1:0] threshold_eff;
  assign threshold_eff = (Threshold_DatIn == '0) ? CountWidth_Gen'(1) : Threshold_DatIn;

  for (genvar i = 0; i < NumberOfInterrupts_Gen; i++) begin : g_chan
    irq_coalescer_chan #(
      .CountWidth_Gen(CountWidth_Gen),
      .TimerWidth_Gen(TimerWidth_Gen)
    ) u_chan (
      .clk         (SysClk_ClkIn),
      .rst_n       (SysRstN_RstIn),
      .enable      (Enable_EnIn),
      .event_pulse (Event_DatIn[i]),
      .threshold   (threshold_eff),
      .holdoff     (Holdoff_DatIn),
      .ovf_clr     (OverflowClr_DatIn[i]),
      .irq         (IrqOut_DatOut[i]),
      .overflow    (Overflow_DatOut[i]),
      .pending     (Pending_DatOut[i])
    );
  end

endmodule
